// File: rtl/data_memory_arb.sv
// ---------------------------------------------------------------------------
// data_memory_arb
//   Single-ported data memory shared by a CPU port and a testbench backdoor
//   port. One access is granted per cycle (CPU first), with a starvation
//   counter that hands the TB port one grant after STARVE_MAX denied cycles.
//   Reads are pipelined with a fixed latency of RD_LAT (1 or 2) cycles.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cpu_req/we/be/addr/wdata   CPU request (byte-lane write enables)
//   o_cpu_gnt                    CPU request accepted this cycle (comb)
//   o_cpu_rvalid/rdata           CPU read response
//   o_cpu_err                    CPU out-of-range access (read: with rvalid,
//                                write: one cycle after the grant)
//   i_tb_req/we/addr/wdata       TB request (full-word writes only)
//   o_tb_gnt, o_tb_rvalid/rdata  TB grant and read response
// ---------------------------------------------------------------------------
module data_memory_arb #(
    parameter int  DATA_W     = 32,
    parameter int  DEPTH      = 1024,
    parameter int  RD_LAT     = 1,
    parameter int  STARVE_MAX = 4,
    localparam int NB         = DATA_W / 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [NB-1:0]     i_cpu_be,
    input  logic [AW-1:0]     i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_err,
    input  logic              i_tb_req,
    input  logic              i_tb_we,
    input  logic [AW-1:0]     i_tb_addr,
    input  logic [DATA_W-1:0] i_tb_wdata,
    output logic              o_tb_gnt,
    output logic              o_tb_rvalid,
    output logic [DATA_W-1:0] o_tb_rdata
);
    localparam int          SW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
    localparam int          L       = RD_LAT - 1;   // index of the output stage

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [SW-1:0]     r_starve;
    logic [RD_LAT-1:0] r_vld;     // read pipeline valid shift register
    logic [RD_LAT-1:0] r_own;     // 1 = response belongs to the CPU port
    logic [RD_LAT-1:0] r_err;     // read was out of range
    logic [DATA_W-1:0] r_data [RD_LAT];
    logic              r_werr;    // CPU out-of-range write, reported next cycle

    logic              w_tb_prio, w_cpu_gnt, w_tb_gnt, w_acc;
    logic              w_we, w_in_rng, w_wr, w_rd, w_out_vld;
    logic [NB-1:0]     w_be;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Arbitration: CPU wins unless the TB has been denied STARVE_MAX cycles.
    assign w_tb_prio = (r_starve == SW'(STARVE_MAX));
    assign w_cpu_gnt = ~i_rst & i_cpu_req & ~(i_tb_req & w_tb_prio);
    assign w_tb_gnt  = ~i_rst & i_tb_req & (~i_cpu_req | w_tb_prio);
    assign w_acc     = w_cpu_gnt | w_tb_gnt;

    // Winner's request onto the single memory port.
    assign w_we     = w_cpu_gnt ? i_cpu_we    : i_tb_we;
    assign w_be     = w_cpu_gnt ? i_cpu_be    : '1;
    assign w_addr   = w_cpu_gnt ? i_cpu_addr  : i_tb_addr;
    assign w_wdata  = w_cpu_gnt ? i_cpu_wdata : i_tb_wdata;
    // DEPTH need not be a power of two, so the address range is checked
    // one bit wider than the address itself.
    assign w_in_rng = ({1'b0, w_addr} < DEPTH_X);
    assign w_wr     = w_acc & w_we & w_in_rng;
    assign w_rd     = w_acc & ~w_we;

    // Memory has no reset: contents survive rst and power up undefined.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    // Read payload pipeline; qualified by r_vld so it needs no reset.
    always_ff @(posedge i_clk) begin
        r_own[0]  <= w_cpu_gnt;
        r_err[0]  <= ~w_in_rng;
        r_data[0] <= w_in_rng ? r_mem[w_addr] : '0;
        for (int s = 1; s < RD_LAT; s++) begin
            r_own[s]  <= r_own[s-1];
            r_err[s]  <= r_err[s-1];
            r_data[s] <= r_data[s-1];
        end
    end

    // Control state; clearing r_vld drops any reads in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= '0;
            r_vld    <= '0;
            r_werr   <= 1'b0;
        end else begin
            r_starve <= (i_tb_req & ~w_tb_gnt) ? r_starve + SW'(1) : '0;
            r_vld[0] <= w_rd;
            for (int s = 1; s < RD_LAT; s++) begin
                r_vld[s] <= r_vld[s-1];
            end
            r_werr   <= w_cpu_gnt & i_cpu_we & ~w_in_rng;
        end
    end

    // Outputs are forced low combinationally while rst is high, so a
    // response due in the reset cycle is suppressed as well.
    assign w_out_vld    = r_vld[L] & ~i_rst;
    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_tb_gnt     = w_tb_gnt;
    assign o_cpu_rvalid = w_out_vld & r_own[L];
    assign o_tb_rvalid  = w_out_vld & ~r_own[L];
    assign o_cpu_rdata  = o_cpu_rvalid ? r_data[L] : '0;
    assign o_tb_rdata   = o_tb_rvalid  ? r_data[L] : '0;
    assign o_cpu_err    = ~i_rst & (r_werr | (o_cpu_rvalid & r_err[L]));

endmodule

// File: tb/tb_data_memory_arb.sv
// Scoreboard bench: two DUTs (RD_LAT=1 and RD_LAT=2, DEPTH=1000) share all
// inputs. Stimulus pushes expected responses tagged with their due cycle;
// a negedge monitor pops and compares whenever a DUT presents rvalid.
module tb_data_memory_arb;
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, tb_req = 1'b0, tb_we = 1'b0;
    logic [3:0]  cpu_be = 4'h0;
    logic [9:0]  cpu_addr = '0, tb_addr = '0;
    logic [31:0] cpu_wdata = '0, tb_wdata = '0;

    logic [1:0]  c_gnt, t_gnt, c_rv, t_rv, c_err;
    logic [31:0] c_rd [2];
    logic [31:0] t_rd [2];

    exp_t        q [4][$];     // 0: dut1 cpu, 1: dut1 tb, 2: dut2 cpu, 3: dut2 tb
    int          werr [2][$];  // expected cpu write-error cycles per DUT
    int          rsp_cnt [4];
    int          cyc = 0;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_arb #(.DATA_W(32), .DEPTH(1000), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_be(cpu_be),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(c_gnt[0]), .o_cpu_rvalid(c_rv[0]), .o_cpu_rdata(c_rd[0]),
        .o_cpu_err(c_err[0]),
        .i_tb_req(tb_req), .i_tb_we(tb_we), .i_tb_addr(tb_addr), .i_tb_wdata(tb_wdata),
        .o_tb_gnt(t_gnt[0]), .o_tb_rvalid(t_rv[0]), .o_tb_rdata(t_rd[0])
    );

    data_memory_arb #(.DATA_W(32), .DEPTH(1000), .RD_LAT(2), .STARVE_MAX(4)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_be(cpu_be),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(c_gnt[1]), .o_cpu_rvalid(c_rv[1]), .o_cpu_rdata(c_rd[1]),
        .o_cpu_err(c_err[1]),
        .i_tb_req(tb_req), .i_tb_we(tb_we), .i_tb_addr(tb_addr), .i_tb_wdata(tb_wdata),
        .o_tb_gnt(t_gnt[1]), .o_tb_rvalid(t_rv[1]), .o_tb_rdata(t_rd[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle CPU access; grant expected immediately (no TB contention).
    task automatic cpu_go(input logic we, input logic [3:0] be, input logic [9:0] a,
                          input logic [31:0] wd, input logic [31:0] xd, input logic xe);
        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = wd;
        #1;
        chk("cpu_gnt", c_gnt, 2'b11);
        if (!we) begin
            q[0].push_back('{cyc + 1, xd, xe});
            q[2].push_back('{cyc + 2, xd, xe});
        end else if (xe) begin
            werr[0].push_back(cyc + 1);
            werr[1].push_back(cyc + 1);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic tb_go(input logic we, input logic [9:0] a,
                         input logic [31:0] wd, input logic [31:0] xd);
        tb_req = 1'b1; tb_we = we; tb_addr = a; tb_wdata = wd;
        #1;
        chk("tb_gnt", t_gnt, 2'b11);
        if (!we) begin
            q[1].push_back('{cyc + 1, xd, 1'b0});
            q[3].push_back('{cyc + 2, xd, 1'b0});
        end
        tick();
        tb_req = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        logic        v, xe;
        logic [31:0] d;
        logic        rerr [2];
        exp_t        e;
        rerr[0] = 1'b0;
        rerr[1] = 1'b0;
        if (rst) begin
            chk("rst_ctrl_outputs", {c_gnt, t_gnt, c_rv, t_rv, c_err}, 64'h0);
            chk("rst_cpu_rdata", {c_rd[0], c_rd[1]}, 64'h0);
            chk("rst_tb_rdata", {t_rd[0], t_rd[1]}, 64'h0);
            for (int i = 0; i < 4; i++) q[i].delete();   // in-flight reads are dropped
            werr[0].delete();
            werr[1].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                v = (i % 2 == 0) ? c_rv[i/2] : t_rv[i/2];
                d = (i % 2 == 0) ? c_rd[i/2] : t_rd[i/2];
                if (v) begin
                    if (q[i].size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_rvalid port %0d @cycle %0d: got rvalid=1, expected 0", i, cyc);
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("rvalid_cycle[%0d]", i), 64'(cyc), 64'(e.cyc));
                        chk($sformatf("rdata[%0d]", i), d, e.data);
                        if (i % 2 == 0) rerr[i/2] = e.err;
                        rsp_cnt[i]++;
                    end
                end else begin
                    chk($sformatf("idle_rdata[%0d]", i), d, 64'h0);
                    if (q[i].size() != 0 && q[i][0].cyc <= cyc) begin
                        n_tests++; n_fail++;
                        $display("FAIL missing_rvalid port %0d @cycle %0d: got rvalid=0, expected 1", i, cyc);
                        void'(q[i].pop_front());
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                xe = rerr[k];
                while (werr[k].size() != 0 && werr[k][0] < cyc) begin
                    n_tests++; n_fail++;
                    $display("FAIL missed_cpu_err dut %0d @cycle %0d: got 0, expected 1", k, werr[k][0]);
                    void'(werr[k].pop_front());
                end
                if (werr[k].size() != 0 && werr[k][0] == cyc) begin
                    xe = 1'b1;
                    void'(werr[k].pop_front());
                end
                if (xe || c_err[k]) chk($sformatf("cpu_err[%0d]", k), c_err[k], xe);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic tbw;
        // Reset with both ports requesting out-of-range reads: no grants.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd1010; cpu_be = 4'hF;
        tb_req  = 1'b1; tb_we  = 1'b0; tb_addr  = 10'd1010;
        repeat (3) begin
            #1;
            chk("rst_cpu_gnt", c_gnt, 2'b00);
            chk("rst_tb_gnt", t_gnt, 2'b00);
            tick();
        end
        rst = 1'b0;
        // Both held high from the first cycle after reset: TB every 5th cycle.
        for (int k = 1; k <= 10; k++) begin
            #1;
            tbw = (k % 5 == 0);
            chk($sformatf("starve_cpu_gnt[%0d]", k), c_gnt, tbw ? 2'b00 : 2'b11);
            chk($sformatf("starve_tb_gnt[%0d]", k), t_gnt, tbw ? 2'b11 : 2'b00);
            if (tbw) begin
                q[1].push_back('{cyc + 1, 32'h0, 1'b0});
                q[3].push_back('{cyc + 2, 32'h0, 1'b0});
            end else begin
                q[0].push_back('{cyc + 1, 32'h0, 1'b1});
                q[2].push_back('{cyc + 2, 32'h0, 1'b1});
            end
            tick();
        end
        cpu_req = 1'b0; tb_req = 1'b0;
        tick();

        // Backdoor write then CPU read-back.
        tb_go(1'b1, 10'd5, 32'hDEADBEEF, 32'h0);
        cpu_go(1'b0, 4'h0, 10'd5, 32'h0, 32'hDEADBEEF, 1'b0);
        // Byte-lane merge.
        tb_go(1'b1, 10'd3, 32'h11223344, 32'h0);
        cpu_go(1'b1, 4'b0101, 10'd3, 32'hAABBCCDD, 32'h0, 1'b0);
        cpu_go(1'b0, 4'h0, 10'd3, 32'h0, 32'h11BB33DD, 1'b0);
        // Write with no lanes enabled changes nothing and raises no error.
        cpu_go(1'b1, 4'b0000, 10'd3, 32'hFFFFFFFF, 32'h0, 1'b0);
        cpu_go(1'b0, 4'h0, 10'd3, 32'h0, 32'h11BB33DD, 1'b0);
        tb_go(1'b0, 10'd5, 32'h0, 32'hDEADBEEF);
        // Last valid word, then out-of-range accesses.
        tb_go(1'b1, 10'd999, 32'h99999999, 32'h0);
        cpu_go(1'b0, 4'h0, 10'd999, 32'h0, 32'h99999999, 1'b0);
        cpu_go(1'b1, 4'hF, 10'd1010, 32'h12345678, 32'h0, 1'b1);
        cpu_go(1'b0, 4'h0, 10'd1010, 32'h0, 32'h0, 1'b1);
        tb_go(1'b0, 10'd1010, 32'h0, 32'h0);
        cpu_go(1'b0, 4'h0, 10'd999, 32'h0, 32'h99999999, 1'b0);
        // Preload words 0..2, then back-to-back pipelined reads.
        for (int k = 0; k < 3; k++) tb_go(1'b1, 10'(k), 32'hA0000000 + 32'(k), 32'h0);
        for (int k = 0; k < 3; k++) cpu_go(1'b0, 4'h0, 10'(k), 32'h0, 32'hA0000000 + 32'(k), 1'b0);
        repeat (3) tick();

        // Reset on the cycle of the 2nd RD_LAT=2 response.
        for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
        for (int k = 0; k < 3; k++) cpu_go(1'b0, 4'h0, 10'(k), 32'h0, 32'hA0000000 + 32'(k), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_drop_lat1_count", 64'(rsp_cnt[0]), 64'd2);
        chk("rst_drop_lat2_count", 64'(rsp_cnt[2]), 64'd1);
        cpu_go(1'b0, 4'h0, 10'd0, 32'h0, 32'hA0000000, 1'b0);
        repeat (4) tick();
        chk("scoreboard_drained",
            64'(q[0].size() + q[1].size() + q[2].size() + q[3].size() + werr[0].size() + werr[1].size()),
            64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
